// File: rtl/capture_trig_pkg.sv
// rtl/capture_trig_pkg.sv - shared state and trigger-mode encodings for the capture engine
package capture_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_VALUE  = 2'd0;
  localparam logic [1:0] MODE_RISE   = 2'd1;
  localparam logic [1:0] MODE_FALL   = 2'd2;
  localparam logic [1:0] MODE_CHANGE = 2'd3;

  function automatic logic is_capturing(input state_t s);
    return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/capture_trig_ram.sv
// rtl/capture_trig_ram.sv - simple dual-port sample RAM, one write port, registered read port
module capture_trig_ram #(
  parameter int W     = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset so the array still maps onto block RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_rdata <= '0;
    else        o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/capture_trig_core.sv
// rtl/capture_trig_core.sv - logic-analyzer capture engine with masked, counted trigger
// Define CAPTURE_TRIG_QUAL_EN to add the store_en storage qualifier port.
module capture_trig_core
  import capture_trig_pkg::*;
#(
  parameter int PROBE_W = 64,
  parameter int DEPTH   = 1024,
  parameter int AW      = $clog2(DEPTH),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROBE_W-1:0] probe,
  input  logic               arm,
  input  logic               abort,
  input  logic [AW-1:0]      pretrig,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [1:0]         trig_mode,
  input  logic [CNT_W-1:0]   trig_count,
`ifdef CAPTURE_TRIG_QUAL_EN
  input  logic               store_en,
`endif
  input  logic [AW-1:0]      rd_addr,
  output logic [PROBE_W-1:0] rd_data,
  output logic               armed,
  output logic               triggered,
  output logic               done,
  output logic [AW-1:0]      trig_addr
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t             r_state, w_state_nxt;
  logic [PROBE_W-1:0] r_p_q, r_p_d;
  logic               r_first;
  logic [AW-1:0]      r_pretrig, r_cnt, r_wptr, r_trig_addr;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_hits;
  logic               w_se, w_hit, w_cap, w_fire, w_we, w_arm_go;
  logic [CNT_W-1:0]   w_target;
  logic [AW-1:0]      w_post_len, w_raddr;

`ifdef CAPTURE_TRIG_QUAL_EN
  logic r_se_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_se_q <= 1'b0;
    else        r_se_q <= store_en;
  end
  assign w_se = r_se_q;
`else
  assign w_se = 1'b1;
`endif

  always_comb begin
    w_hit = 1'b0;
    case (r_mode)
      MODE_VALUE: w_hit = ((r_p_q ^ trig_value) & trig_mask) == '0;
      MODE_RISE:  w_hit = |(~r_p_d & r_p_q & trig_mask);
      MODE_FALL:  w_hit = |(r_p_d & ~r_p_q & trig_mask);
      default:    w_hit = |((r_p_d ^ r_p_q) & trig_mask);
    endcase
  end

  // r_first masks the arm-cycle sample still sitting in r_p_q.
  assign w_arm_go   = arm && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_cap      = is_capturing(r_state) && !r_first;
  assign w_target   = (trig_count == '0) ? CNT_W'(1) : trig_count;
  assign w_fire     = (r_state == ST_WAIT) && w_cap && w_hit && (r_hits == w_target - 1'b1);
  assign w_we       = w_cap && (w_se || w_fire);
  assign w_post_len = LAST_IDX - r_pretrig;
  assign w_raddr    = r_trig_addr - r_pretrig + rd_addr;

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE:
          if (arm) w_state_nxt = (pretrig == '0) ? ST_WAIT : ST_PRE;
        ST_PRE:
          if (w_we && r_cnt == r_pretrig - 1'b1) w_state_nxt = ST_WAIT;
        ST_WAIT:
          if (w_fire) w_state_nxt = (w_post_len == '0) ? ST_DONE : ST_POST;
        ST_POST:
          if (w_we && r_cnt == w_post_len - 1'b1) w_state_nxt = ST_DONE;
        default:
          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_q       <= '0;
      r_p_d       <= '0;
      r_first     <= 1'b0;
      r_pretrig   <= '0;
      r_mode      <= MODE_VALUE;
      r_cnt       <= '0;
      r_hits      <= '0;
      r_wptr      <= '0;
      r_trig_addr <= '0;
    end else begin
      r_p_q   <= probe;
      r_p_d   <= r_p_q;
      r_first <= w_arm_go;
      if (w_arm_go) begin
        r_pretrig <= pretrig;
        r_mode    <= trig_mode;
      end
      // r_cnt counts stored samples within the current phase.
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_we)              r_cnt <= r_cnt + 1'b1;
      if (w_arm_go)                                   r_hits <= '0;
      else if (r_state == ST_WAIT && w_cap && w_hit)  r_hits <= r_hits + 1'b1;
      if (w_we)   r_wptr      <= r_wptr + 1'b1;
      if (w_fire) r_trig_addr <= r_wptr;
    end
  end

  capture_trig_ram #(
    .W    (PROBE_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_waddr(r_wptr),
    .i_wdata(r_p_q),
    .i_raddr(w_raddr),
    .o_rdata(rd_data)
  );

  assign armed     = is_capturing(r_state);
  assign triggered = (r_state == ST_POST) || (r_state == ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign trig_addr = r_trig_addr;

endmodule

// File: doc/capture_trig_core.md
# capture_trig_core

Parametrised on-chip logic-analyzer capture engine: samples a PROBE_W-bit probe bus every `clk` into a DEPTH-entry circular buffer. It stops on a programmable masked trigger (value, rising, falling or any-change) after a configurable post-trigger window. Frozen samples are read back oldest-first through a random-access port. It is the next-generation debug capture core beside the debug-hub wrapper, generalising fixed-width probe capture with a pre-trigger position, trigger modes and qualified trigger counting.

## Interface
- PROBE_W, 64, probe bus width (1..1024)
- DEPTH, 1024, buffer entries, power of two (16..65536)
- AW, $clog2(DEPTH), address width (derived, do not override)
- CNT_W, 16, trigger occurrence counter width
- clk  in  1  sample clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- probe  in  PROBE_W  sampled bus
- arm  in  1  one-cycle pulse: start capture (ignored unless IDLE or DONE)
- abort  in  1  return to IDLE from any state
- pretrig  in  AW  samples kept before trigger, latched at arm
- trig_mask  in  PROBE_W  1 = bit participates in trigger
- trig_value  in  PROBE_W  compare value (mode VALUE)
- trig_mode  in  2  0 VALUE, 1 RISE, 2 FALL, 3 CHANGE; latched at arm
- trig_count  in  CNT_W  trigger fires on the Nth qualifying hit (0 treated as 1)
- store_en  in  1  storage qualifier (only with CAPTURE_TRIG_QUAL_EN)
- rd_addr  in  AW  logical read index, 0 = oldest
- rd_data  out  PROBE_W  buffer word, 1-cycle latency
- armed  out  1  high in PRE, WAIT, POST
- triggered  out  1  high from trigger cycle until next arm/abort
- done  out  1  capture frozen, buffer readable
- trig_addr  out  AW  physical address of trigger sample

## Operation
- Probe registered once (p_q); previous registered value p_d kept for edge modes; trigger and write both act on p_q.
- Hit: VALUE = ((p_q ^ trig_value) & mask)==0; RISE = |(~p_d & p_q & mask); FALL = |(p_d & ~p_q & mask); CHANGE = |((p_d ^ p_q) & mask). mask all-zero: VALUE always hits, edge modes never hit.
- States: IDLE → (arm) PRE → (pretrig samples stored) WAIT → (Nth hit) POST → (DEPTH-1-pretrig further samples) DONE → (arm) PRE.
- pretrig=0: arm goes directly to WAIT. pretrig latched at arm; values ≥ DEPTH impossible by width, DEPTH-1 allowed (POST length 0, DONE the cycle after trigger).
- Hits in PRE are ignored and not counted; the hit counter clears at arm.
- WAIT: write pointer wraps modulo DEPTH, overwriting oldest data.
- Trigger sample is written; trig_addr = its write address. Start address = trig_addr − pretrig mod DEPTH.
- Read: physical = start + rd_addr mod DEPTH; rd_data valid the cycle after rd_addr; reading outside DONE returns undefined data, no side effects.
- abort wins over arm in the same cycle; in any state it goes to IDLE and clears armed, triggered and done.
- arm while armed is ignored.

## Timing
- Reset: state IDLE; armed, triggered, done = 0; trig_addr = 0; rd_data = 0; pointers, counters and p_q/p_d = 0.
- arm in cycle t: armed=1 at t+1; the first stored sample is probe from cycle t+1.
- Trigger-to-triggered: 2 cycles from the probe change (1 input register + state update).
- done asserts the cycle after the last POST write; total writes from arm to done ≥ DEPTH.
- Buffer RAM: one write port, one read port, single clock, no read-during-write hazard (writes stop in DONE).

## Configuration
- CAPTURE_TRIG_QUAL_EN defined: store_en gates writes and pointer advance in all capture states. PRE/POST count only stored samples. A trigger hit while store_en=0 still counts but the trigger sample is forced stored.
- Undefined: store_en port absent, every cycle is stored.

## Structure
- Package capture_trig_pkg: state enum (IDLE, PRE, WAIT, POST, DONE), trig_mode encoding constants.
- Sub-module capture_trig_ram: simple dual-port DEPTH×PROBE_W RAM with registered read, inferable as block RAM.

## Test plan
- DEPTH=16, pretrig=4, VALUE mask=0xFF value=0x2A, probe = counter from 0x20 → trigger at 0x2A; rd 0..15 = 0x26..0x35, trig_addr consistent.
- RISE on bit 3, trig_count=3 → trigger on third 0→1 of bit 3; first two ignored; a hit during PRE not counted.
- pretrig=0 and pretrig=15 → buffer starts at trigger sample / ends at trigger sample; done one cycle after trigger for 15.
- abort during POST, then arm simultaneous with abort → IDLE, all flags 0; next arm captures normally.
- Async rst_n low mid-WAIT → all outputs reset immediately, no write after release until arm.
- CAPTURE_TRIG_QUAL_EN, store_en every other cycle → buffer holds only even samples, trigger sample present even if it fell on an odd cycle.
